scsi_bus_arbiter: RTL and testbench

Arbitrates the SCSI controller IC between CPU register accesses and DMA byte transfers. Sits between the CPU address decode, the raw SCSI IC DREQ line and the SCSI transfer state machine. It produces the state machine's `CCPUREQ` and gated `CDREQ_` inputs so that only one owner is ever presented at a time. A DMA burst is limited in length so a pending CPU access is never starved.

---
 rtl/scsi_bus_arbiter.sv | 81 ++++++++
 tb/tb_scsi_bus_arbiter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/scsi_bus_arbiter.sv
// scsi_bus_arbiter: shares the SCSI IC between CPU register accesses and length-limited DMA bursts.
// Optional watchdog on stuck CPU waits is built only when SCSI_ARB_WATCHDOG_EN is defined.
module scsi_bus_arbiter #(
    parameter int BURST_LEN = 16,
    parameter int WD_LIMIT  = 255
) (
    input  logic       CLK,
    input  logic       nRESET,
    input  logic       CPUREQ_IN,
    input  logic       DREQ_,
    input  logic       DMAENA,
    input  logic       SM_IDLE,
    input  logic       INCBO,
    output logic       CCPUREQ,
    output logic       CDREQ_,
    output logic       GNT_CPU,
    output logic       GNT_DMA,
    output logic [7:0] BURST_CNT,
    output logic       ARB_TIMEOUT
);
    typedef enum logic [2:0] {IDLE, DMA_OWN, CPU_WAIT, CPU_GRANT, CPU_BUSY} state_t;
    localparam logic [7:0] blen = 8'(BURST_LEN);
    state_t state, nxt;
    logic [1:0] idle_cnt;
    logic wd_hit;
`ifdef SCSI_ARB_WATCHDOG_EN
    localparam int WDW = $clog2(WD_LIMIT + 1);
    logic [WDW-1:0] wd_cnt;
    logic wd_state;
    assign wd_state = (state == CPU_WAIT) || (state == CPU_BUSY);
    assign wd_hit = wd_state && (wd_cnt == WDW'(WD_LIMIT - 1));
    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            wd_cnt      <= '0;
            ARB_TIMEOUT <= 1'b0;
        end else begin
            wd_cnt      <= (wd_state && !wd_hit) ? wd_cnt + 1'b1 : '0;
            ARB_TIMEOUT <= wd_hit;
        end
    end
`else
    localparam int unused_wd_limit = WD_LIMIT;
    assign wd_hit      = 1'b0;
    assign ARB_TIMEOUT = 1'b0;
`endif
    always_comb begin
        nxt = state;
        case (state)
            IDLE:      nxt = CPUREQ_IN ? CPU_WAIT : (!DREQ_ && DMAENA) ? DMA_OWN : IDLE;
            DMA_OWN:   nxt = (CPUREQ_IN && (BURST_CNT == blen || DREQ_ || !DMAENA)) ? CPU_WAIT :
                             (!DMAENA || (DREQ_ && SM_IDLE)) ? IDLE : DMA_OWN;
            CPU_WAIT:  nxt = !CPUREQ_IN ? IDLE : (idle_cnt == 2'd2) ? CPU_GRANT : CPU_WAIT;
            CPU_GRANT: nxt = SM_IDLE ? CPU_GRANT : CPU_BUSY;
            CPU_BUSY:  nxt = (SM_IDLE && !CPUREQ_IN) ? IDLE : CPU_BUSY;
            default:   nxt = IDLE;
        endcase
        if (wd_hit) nxt = IDLE;
    end
    // idle_cnt counts consecutive SM_IDLE samples in CPU_WAIT; two are needed to cover the mask latency
    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            state     <= IDLE;
            idle_cnt  <= 2'd0;
            CCPUREQ   <= 1'b0;
            CDREQ_    <= 1'b1;
            GNT_CPU   <= 1'b0;
            GNT_DMA   <= 1'b0;
            BURST_CNT <= 8'd0;
        end else begin
            state     <= nxt;
            idle_cnt  <= (state != CPU_WAIT || !SM_IDLE) ? 2'd0 :
                         (idle_cnt == 2'd2) ? idle_cnt : idle_cnt + 2'd1;
            CCPUREQ   <= nxt == CPU_GRANT;
            CDREQ_    <= (nxt == DMA_OWN) ? DREQ_ : 1'b1;
            GNT_CPU   <= nxt inside {CPU_WAIT, CPU_GRANT, CPU_BUSY};
            GNT_DMA   <= nxt == DMA_OWN;
            BURST_CNT <= (state != DMA_OWN && nxt == DMA_OWN) ? 8'd0 :
                         (state == DMA_OWN && INCBO && BURST_CNT < blen) ? BURST_CNT + 8'd1 : BURST_CNT;
        end
    end
endmodule

// File: tb/tb_scsi_bus_arbiter.sv
// tb_scsi_bus_arbiter: table-driven directed vectors plus hand-written DMA, burst-limit, reset and watchdog sequences.
module tb_scsi_bus_arbiter;
`ifdef SCSI_ARB_WATCHDOG_EN
    localparam int WDL = 20;
`else
    localparam int WDL = 255;
`endif
    logic clk = 1'b0;
    logic nreset, cpureq_in, dreq_n, dmaena, sm_idle, incbo;
    logic ccpureq, cdreq_n, gnt_cpu, gnt_dma, arb_timeout;
    logic [7:0] burst_cnt;
    int vectors = 0;
    int errors = 0;

    scsi_bus_arbiter #(.BURST_LEN(16), .WD_LIMIT(WDL)) dut (
        .CLK(clk), .nRESET(nreset), .CPUREQ_IN(cpureq_in), .DREQ_(dreq_n), .DMAENA(dmaena),
        .SM_IDLE(sm_idle), .INCBO(incbo), .CCPUREQ(ccpureq), .CDREQ_(cdreq_n), .GNT_CPU(gnt_cpu),
        .GNT_DMA(gnt_dma), .BURST_CNT(burst_cnt), .ARB_TIMEOUT(arb_timeout)
    );

    always #5 clk = ~clk;

    // in = {cpureq, dreq_, dmaena, sm_idle, incbo}; out = {ccpureq, cdreq_, gnt_cpu, gnt_dma, timeout}
    typedef struct packed {
        logic [4:0] in;
        logic [4:0] out;
        logic [7:0] cnt;
    } vec_t;
    vec_t tbl [37];

    task automatic step(input logic [4:0] in);
        {cpureq_in, dreq_n, dmaena, sm_idle, incbo} = in;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [4:0] o, input logic [7:0] c);
        vectors++;
        if ({ccpureq, cdreq_n, gnt_cpu, gnt_dma, arb_timeout, burst_cnt} !== {o, c}) begin
            errors++;
            $display("FAIL %s: got out=%b cnt=%0d, want out=%b cnt=%0d", name,
                     {ccpureq, cdreq_n, gnt_cpu, gnt_dma, arb_timeout}, burst_cnt, o, c);
        end
    endtask

    initial begin
        tbl = '{
            '{5'b11010, 5'b01100, 8'd0}, '{5'b11010, 5'b01100, 8'd0}, '{5'b11010, 5'b01100, 8'd0},
            '{5'b11010, 5'b11100, 8'd0}, '{5'b11010, 5'b11100, 8'd0}, '{5'b11000, 5'b01100, 8'd0},
            '{5'b11010, 5'b01100, 8'd0}, '{5'b01010, 5'b01000, 8'd0}, '{5'b01010, 5'b01000, 8'd0},
            '{5'b11000, 5'b01100, 8'd0}, '{5'b11010, 5'b01100, 8'd0}, '{5'b01010, 5'b01000, 8'd0},
            '{5'b11010, 5'b01100, 8'd0}, '{5'b11010, 5'b01100, 8'd0}, '{5'b11000, 5'b01100, 8'd0},
            '{5'b11010, 5'b01100, 8'd0}, '{5'b11010, 5'b01100, 8'd0}, '{5'b11010, 5'b11100, 8'd0},
            '{5'b11000, 5'b01100, 8'd0}, '{5'b01010, 5'b01000, 8'd0}, '{5'b10110, 5'b01100, 8'd0},
            '{5'b10110, 5'b01100, 8'd0}, '{5'b10110, 5'b01100, 8'd0}, '{5'b10110, 5'b11100, 8'd0},
            '{5'b10100, 5'b01100, 8'd0}, '{5'b00110, 5'b01000, 8'd0}, '{5'b00110, 5'b00010, 8'd0},
            '{5'b00101, 5'b00010, 8'd1}, '{5'b01100, 5'b01010, 8'd1}, '{5'b00101, 5'b00010, 8'd2},
            '{5'b00000, 5'b01000, 8'd2}, '{5'b00010, 5'b01000, 8'd2}, '{5'b00110, 5'b00010, 8'd0},
            '{5'b01110, 5'b01000, 8'd0}, '{5'b00110, 5'b00010, 8'd0}, '{5'b11110, 5'b01100, 8'd0},
            '{5'b01110, 5'b01000, 8'd0}
        };
        nreset = 1'b0;
        step(5'b01010);
        step(5'b01010);
        check("reset", 5'b01000, 8'd0);
        nreset = 1'b1;
        step(5'b01010);
        check("idle_after_reset", 5'b01000, 8'd0);

        for (int i = 0; i < 37; i++) begin
            step(tbl[i].in);
            check($sformatf("tbl[%0d]", i), tbl[i].out, tbl[i].cnt);
        end

        // uncontended DMA: count saturates at BURST_LEN, CDREQ_ tracks DREQ_ one cycle late
        step(5'b00100);
        check("dma_enter", 5'b00010, 8'd0);
        for (int i = 1; i <= 40; i++) begin
            step(5'b00101);
            check($sformatf("dma_byte%0d", i), 5'b00010, 8'(i < 16 ? i : 16));
        end
        step(5'b01100);
        check("dma_lag_high", 5'b01010, 8'd16);
        step(5'b00100);
        check("dma_lag_low", 5'b00010, 8'd16);
        step(5'b00000);
        check("dmaena_drop", 5'b01000, 8'd16);

        // burst limit: CPU request from byte 3 waits for the 16th byte
        step(5'b00100);
        check("burst_enter", 5'b00010, 8'd0);
        for (int i = 1; i <= 16; i++) begin
            step({i >= 3, 4'b0101});
            check($sformatf("burst_byte%0d", i), 5'b00010, 8'(i));
        end
        step(5'b10110);
        check("burst_to_wait", 5'b01100, 8'd16);
        step(5'b10110);
        check("burst_wait1", 5'b01100, 8'd16);
        step(5'b10110);
        check("burst_wait2", 5'b01100, 8'd16);
        step(5'b10110);
        check("burst_grant", 5'b11100, 8'd16);
        step(5'b10100);
        check("burst_busy", 5'b01100, 8'd16);
        step(5'b00110);
        check("burst_idle", 5'b01000, 8'd16);
        step(5'b00110);
        check("dma_after_cpu", 5'b00010, 8'd0);

        // reset while granted
        step(5'b11010);
        check("rst_wait", 5'b01100, 8'd0);
        step(5'b11010);
        step(5'b11010);
        step(5'b11010);
        check("rst_grant", 5'b11100, 8'd0);
        nreset = 1'b0;
        step(5'b11010);
        check("rst_mid_grant", 5'b01000, 8'd0);
        nreset = 1'b1;
        step(5'b01010);
        check("rst_release", 5'b01000, 8'd0);

`ifdef SCSI_ARB_WATCHDOG_EN
        step(5'b11000);
        check("wd_entry", 5'b01100, 8'd0);
        for (int k = 1; k < 20; k++) begin
            step(5'b11000);
            check($sformatf("wd_wait%0d", k), 5'b01100, 8'd0);
        end
        step(5'b11000);
        check("wd_expire", 5'b01001, 8'd0);
        step(5'b01000);
        check("wd_pulse_end", 5'b01000, 8'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
